// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM for the 16-bit CPU: fetch, decode, execute and
// memory write-back sequencing. Owns the instruction register, drives the
// PC, memory, register-file and flag-register controls.
// Ports:
//   clk, rst         - rising-edge clock, asynchronous active-high reset
//   run              - start/continue, only looked at in S_FETCH
//   mem_dout[15:0]   - synchronous memory read data (valid the cycle after address)
//   flags[4:0]       - {C,L,F,Z,N} from the flag register
//   mem_ready        - memory handshake, present only with SEQ_WAIT_STATE_EN
//   ir[15:0]         - latched instruction (rdest=ir[11:8], rsrc=ir[3:0])
//   pc_en/pc_sel/pc_imm - PC update strobe, source select, branch displacement
//   addr_sel         - memory address source (0 PC, 1 register rsrc)
//   mem_we, rf_we, wb_sel, flags_we - memory / register / flag write controls
//   state[2:0]       - current FSM state, for debug
// Optional feature macro: SEQ_WAIT_STATE_EN (adds mem_ready wait states).
module instr_sequencer #(
  parameter logic [15:0] RESET_IR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] mem_dout,
  input  logic [4:0]  flags,
`ifdef SEQ_WAIT_STATE_EN
  input  logic        mem_ready,
`endif
  output logic [15:0] ir,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic [15:0] pc_imm,
  output logic        addr_sel,
  output logic        mem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        flags_we,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEMWB  = 3'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        ready;
  logic        cond_true;
  logic [3:0]  op, ext, cond;

  // Without wait states the memory always answers in one cycle.
`ifdef SEQ_WAIT_STATE_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  assign op   = ir_q[15:12];
  assign ext  = ir_q[7:4];
  assign cond = ir_q[11:8];

  // Flag bit positions: C=4, L=3, F=2, Z=1, N=0.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'b0000: cond_true =  flags[1];
      4'b0001: cond_true = ~flags[1];
      4'b0010: cond_true =  flags[4];
      4'b0011: cond_true = ~flags[4];
      4'b0100: cond_true =  flags[3];
      4'b0101: cond_true = ~flags[3];
      4'b0110: cond_true =  flags[0];
      4'b0111: cond_true = ~flags[0];
      4'b1000: cond_true =  flags[2];
      4'b1001: cond_true = ~flags[2];
      4'b1010: cond_true = ~flags[3] & ~flags[1];
      4'b1011: cond_true =  flags[3] |  flags[1];
      4'b1100: cond_true = ~flags[0] & ~flags[1];
      4'b1101: cond_true =  flags[0] |  flags[1];
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_en    = 1'b0;
    pc_sel   = 2'b00;
    addr_sel = 1'b0;
    mem_we   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 2'b00;
    flags_we = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Fetched word arrives now; PC advances exactly once per instruction.
        if (ready) begin
          ir_d    = mem_dout;
          pc_en   = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          4'b0100: begin
            case (ext)
              4'b0000: begin
                addr_sel = 1'b1;
                state_d  = S_MEMWB;
              end
              4'b0100: begin
                // Store holds its write strobe until memory accepts it.
                addr_sel = 1'b1;
                mem_we   = 1'b1;
                if (!ready) state_d = S_EXEC;
              end
              4'b1000: begin
                rf_we  = 1'b1;
                wb_sel = 2'b10;
                pc_en  = 1'b1;
                pc_sel = 2'b10;
              end
              4'b1100: begin
                if (cond_true) begin
                  pc_en  = 1'b1;
                  pc_sel = 2'b10;
                end
              end
              default: ;
            endcase
          end
          4'b1100: begin
            if (cond_true) begin
              pc_en  = 1'b1;
              pc_sel = 2'b01;
            end
          end
          default: begin
            rf_we    = 1'b1;
            flags_we = 1'b1;
          end
        endcase
      end
      S_MEMWB: begin
        addr_sel = 1'b1;
        wb_sel   = 2'b01;
        rf_we    = ready;
        if (ready) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= RESET_IR;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign ir     = ir_q;
  assign state  = state_q;
  assign pc_imm = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] mem_dout;
  logic [4:0]  flags;
  logic        mem_ready;
  logic [15:0] ir;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic [15:0] pc_imm;
  logic        addr_sel;
  logic        mem_we;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        flags_we;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       pe;
    logic [1:0] ps;
    logic       as;
    logic       mw;
    logic       rw;
    logic [1:0] wb;
    logic       fw;
  } exp_t;

  exp_t sb[$];

  instr_sequencer #(.RESET_IR(16'h0000)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_dout(mem_dout), .flags(flags),
`ifdef SEQ_WAIT_STATE_EN
    .mem_ready(mem_ready),
`endif
    .ir(ir), .pc_en(pc_en), .pc_sel(pc_sel), .pc_imm(pc_imm),
    .addr_sel(addr_sel), .mem_we(mem_we), .rf_we(rf_we), .wb_sel(wb_sel),
    .flags_we(flags_we), .state(state)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [2:0] st, logic pe, logic [1:0] ps, logic as,
                              logic mw, logic rw, logic [1:0] wb, logic fw);
    exp_t e;
    e = {st, pe, ps, as, mw, rw, wb, fw};
    return e;
  endfunction

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; compares the control outputs against
  // the oldest scoreboard entry, then optionally advances to the next falling edge.
  task automatic check_cycle(input string tag, input bit adv);
    exp_t e, o;
    #1;
    o = {state, pc_en, pc_sel, addr_sel, mem_we, rf_we, wb_sel, flags_we};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, o);
    end else begin
      e = sb.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
    end
    if (adv) @(negedge clk);
  endtask

  // One complete instruction starting in S_FETCH. run is dropped after the
  // fetch to show it is ignored mid-instruction.
  task automatic run_instr(input string tag, input logic [15:0] instr, input logic [4:0] f,
                           input exp_t e_exec, input bit has_mw, input exp_t e_mw);
    run = 1'b1; mem_dout = instr; flags = f;
    sb.push_back(mk(3'd0, 0, 2'b00, 0, 0, 0, 2'b00, 0));
    sb.push_back(mk(3'd1, 1, 2'b00, 0, 0, 0, 2'b00, 0));
    sb.push_back(e_exec);
    if (has_mw) sb.push_back(e_mw);
    check_cycle({tag, "_fetch"}, 1);
    run = 1'b0;
    check_cycle({tag, "_decode"}, 1);
    check_cycle({tag, "_exec"}, 1);
    if (has_mw) check_cycle({tag, "_memwb"}, 1);
    chk16({tag, "_ir"}, ir, instr);
    chk16({tag, "_imm"}, pc_imm, {{8{instr[7]}}, instr[7:0]});
  endtask

  exp_t        z;
  logic [15:0] taken_tbl;
  logic [15:0] op_ir;

  initial begin
    z = mk(3'd0, 0, 2'b00, 0, 0, 0, 2'b00, 0);
    rst = 1'b1; run = 1'b0; mem_dout = 16'h0000; flags = 5'b00000; mem_ready = 1'b1;

    // Reset state
    sb.push_back(z);
    check_cycle("reset", 0);
    chk16("reset_ir", ir, 16'h0000);
    chk16("reset_imm", pc_imm, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Register ALU
    run_instr("alu", 16'h0125, 5'b00000, mk(3'd2, 0, 2'b00, 0, 0, 1, 2'b00, 1), 0, z);
    // Immediate ALU
    run_instr("alui", 16'h5A07, 5'b00000, mk(3'd2, 0, 2'b00, 0, 0, 1, 2'b00, 1), 0, z);
    // Bcond EQ taken (Z=1), then not taken (Z=0)
    run_instr("beq_t", 16'hC0FE, 5'b00010, mk(3'd2, 1, 2'b01, 0, 0, 0, 2'b00, 0), 0, z);
    run_instr("beq_n", 16'hC0FE, 5'b00000, z | mk(3'd2, 0, 2'b00, 0, 0, 0, 2'b00, 0), 0, z);
    // LOAD: four-cycle instruction
    run_instr("load", 16'h4203, 5'b00000, mk(3'd2, 0, 2'b00, 1, 0, 0, 2'b00, 0), 1,
              mk(3'd3, 0, 2'b00, 1, 0, 1, 2'b01, 0));
    // JAL
    run_instr("jal", 16'h4E85, 5'b00000, mk(3'd2, 1, 2'b10, 0, 0, 1, 2'b10, 0), 0, z);
    // STOR: single mem_we cycle, then back to idle fetch
    run_instr("stor", 16'h4143, 5'b00000, mk(3'd2, 0, 2'b00, 1, 1, 0, 2'b00, 0), 0, z);
    // Jcond always / never, and an undefined ext treated as NOP
    run_instr("juc", 16'h4EC0, 5'b00000, mk(3'd2, 1, 2'b10, 0, 0, 0, 2'b00, 0), 0, z);
    run_instr("jnv", 16'h4FC0, 5'b11111, mk(3'd2, 0, 2'b00, 0, 0, 0, 2'b00, 0), 0, z);
    run_instr("nop", 16'h4010, 5'b00000, mk(3'd2, 0, 2'b00, 0, 0, 0, 2'b00, 0), 0, z);
    // Bcond LT with N=0,Z=0 taken; displacement 8'h80 -> 16'hFF80
    run_instr("blt", 16'hCC80, 5'b00000, mk(3'd2, 1, 2'b01, 0, 0, 0, 2'b00, 0), 0, z);

    // Every condition code with C=1,L=0,F=1,Z=0,N=1; bit i = cond i taken
    taken_tbl = 16'h6566;
    for (int c = 0; c < 16; c++) begin
      op_ir = {4'hC, c[3:0], 8'h03};
      if (taken_tbl[c])
        run_instr("bcond", op_ir, 5'b10101, mk(3'd2, 1, 2'b01, 0, 0, 0, 2'b00, 0), 0, z);
      else
        run_instr("bcond", op_ir, 5'b10101, mk(3'd2, 0, 2'b00, 0, 0, 0, 2'b00, 0), 0, z);
    end

    // Idle: run=0 for 5 cycles holds S_FETCH with no PC change
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(z);
      check_cycle("idle", 1);
    end

    // Reset asserted during STOR execute aborts immediately
    run = 1'b1; mem_dout = 16'h4143;
    sb.push_back(mk(3'd0, 0, 2'b00, 0, 0, 0, 2'b00, 0));
    sb.push_back(mk(3'd1, 1, 2'b00, 0, 0, 0, 2'b00, 0));
    sb.push_back(mk(3'd2, 0, 2'b00, 1, 1, 0, 2'b00, 0));
    check_cycle("rst_fetch", 1);
    check_cycle("rst_decode", 1);
    check_cycle("rst_exec", 0);
    rst = 1'b1;
    sb.push_back(z);
    check_cycle("rst_abort", 0);
    chk16("rst_abort_ir", ir, 16'h0000);
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    sb.push_back(z);
    check_cycle("rst_after", 1);

`ifdef SEQ_WAIT_STATE_EN
    // LOAD with memory stalling for 3 cycles in S_MEMWB
    run = 1'b1; mem_dout = 16'h4203; mem_ready = 1'b1;
    sb.push_back(mk(3'd0, 0, 2'b00, 0, 0, 0, 2'b00, 0));
    sb.push_back(mk(3'd1, 1, 2'b00, 0, 0, 0, 2'b00, 0));
    sb.push_back(mk(3'd2, 0, 2'b00, 1, 0, 0, 2'b00, 0));
    check_cycle("wl_fetch", 1);
    run = 1'b0;
    check_cycle("wl_decode", 1);
    check_cycle("wl_exec", 1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(3'd3, 0, 2'b00, 1, 0, 0, 2'b01, 0));
      check_cycle("wl_hold", 1);
    end
    mem_ready = 1'b1;
    sb.push_back(mk(3'd3, 0, 2'b00, 1, 0, 1, 2'b01, 0));
    check_cycle("wl_done", 1);
    sb.push_back(z);
    check_cycle("wl_back", 1);
`endif

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed %0d leftover expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit CPU.
- Fetches each instruction, latches it into an internal instruction register, decodes opcode/ext fields, and sequences the program counter, memory port, register file and flag register.
- Drives the PC's pc_en/sel/imm controls and selects the memory address source.
- One instruction retires every 3 or 4 cycles.

Parameters:
- RESET_IR, 16'h0000, IR value loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  start/continue; sampled only in S_FETCH.
- mem_dout  in  16  synchronous memory read data; valid the cycle after the address is driven.
- flags  in  5  {C,L,F,Z,N} from the flag register.
- ir  out  16  latched instruction; rdest=ir[11:8], rsrc=ir[3:0].
- pc_en  out  1  PC update strobe.
- pc_sel  out  2  PC source: 00 increment, 01 relative imm, 10 register address.
- pc_imm  out  16  sign-extended ir[7:0] branch displacement.
- addr_sel  out  1  memory address source: 0 = PC, 1 = register rsrc.
- mem_we  out  1  memory write strobe.
- rf_we  out  1  register file write enable.
- wb_sel  out  2  write-back source: 00 ALU, 01 memory, 10 PC (link).
- flags_we  out  1  flag register write enable.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset (async, rst=1):
  - state=S_FETCH, ir=RESET_IR.
  - All strobes 0; pc_sel=00, addr_sel=0, wb_sel=00.
  - pc_imm = sext(RESET_IR[7:0]).
- All outputs are combinational from state and ir, except ir and state, which are registered.
- States: S_FETCH=0, S_DECODE=1, S_EXEC=2, S_MEMWB=3.
- S_FETCH:
  - addr_sel=0.
  - If run=1, go to S_DECODE; otherwise stay. No PC change while idle.
- S_DECODE:
  - ir <= mem_dout.
  - pc_en=1, pc_sel=00 (PC+1).
  - Go to S_EXEC.
- S_EXEC, decoded from ir:
  - Register ALU (op=0000) or immediate ALU (op not 0100 and not 1100): rf_we=1, wb_sel=00, flags_we=1. Next S_FETCH.
  - LOAD (op=0100, ext=0000): addr_sel=1. Next S_MEMWB.
  - STOR (op=0100, ext=0100): addr_sel=1, mem_we=1. Next S_FETCH.
  - JAL (op=0100, ext=1000): rf_we=1, wb_sel=10, pc_en=1, pc_sel=10. Next S_FETCH.
  - Jcond (op=0100, ext=1100): if cond(ir[11:8]) is true, pc_en=1, pc_sel=10. Next S_FETCH.
  - Bcond (op=1100): if cond(ir[11:8]) is true, pc_en=1, pc_sel=01. Next S_FETCH.
  - Any other op=0100 ext: treated as NOP. Next S_FETCH.
- S_MEMWB: addr_sel=1, rf_we=1, wb_sel=01. Next S_FETCH.
- Condition codes (cond value: test):
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 HI: L
  - 0101 LS: !L
  - 0110 GT: N
  - 0111 LE: !N
  - 1000 FS: F
  - 1001 FC: !F
  - 1010 LO: !L & !Z
  - 1011 HS: L | Z
  - 1100 LT: !N & !Z
  - 1101 GE: N | Z
  - 1110 UC: always
  - 1111: never
- Boundary conditions:
  - Untaken branch/jump: no pc_en in S_EXEC; the PC keeps its S_DECODE increment.
  - Exactly one pc_en pulse in S_DECODE per instruction, plus at most one in S_EXEC. pc_en is never asserted in S_FETCH or S_MEMWB.
  - run is ignored mid-instruction; deassertion takes effect at the next S_FETCH.
  - rst mid-instruction aborts it immediately. Outputs drop in the same cycle, with no partial write.
  - pc_imm is always sext(ir[7:0]); 8'h80 gives 16'hFF80.

Optional Feature:
- Macro: SEQ_WAIT_STATE_EN.
- With the macro defined:
  - Adds input mem_ready (1 bit).
  - S_DECODE latches ir and pulses pc_en only when mem_ready=1; otherwise it holds with pc_en=0.
  - The LOAD S_MEMWB and STOR S_EXEC states hold until mem_ready=1. mem_we stays asserted while holding; rf_we is asserted only in the mem_ready=1 cycle.
- Without the macro: there is no mem_ready port, and memory has a fixed one-cycle latency.

Test Plan:
- Reset, then run=1 with mem_dout=16'h0125 (ALU): states 0,1,2,0; one pc_en (sel 00) in S_DECODE; rf_we=1, flags_we=1 in S_EXEC.
- Bcond ir=16'hC0FE, flags Z=1: S_EXEC gives pc_en=1, pc_sel=01, pc_imm=16'hFFFE. Repeat with Z=0: no pc_en in S_EXEC.
- LOAD ir=16'h4203: addr_sel=1 in S_EXEC and S_MEMWB; rf_we=1, wb_sel=01 only in S_MEMWB; 4-cycle instruction.
- JAL ir=16'h4E85: rf_we=1, wb_sel=10, pc_en=1, pc_sel=10 in the same cycle. STOR ir=16'h4143: mem_we=1 for exactly one cycle.
- run=0 in S_FETCH for 5 cycles: state stays 0, pc_en=0. Assert rst in S_EXEC of a STOR: mem_we drops immediately; state=0, ir=16'h0000.
- With SEQ_WAIT_STATE_EN, LOAD with mem_ready low for 3 cycles in S_MEMWB: hold there, rf_we=0, then rf_we=1 for one cycle when mem_ready=1.
